// File: rtl/toy_bus_pkg.sv
// rtl/toy_bus_pkg.sv - shared toy bus widths, opcodes, node ids and request payload type
package toy_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 256;
    localparam int STRB_W = 32;
    localparam int SB_W   = 10;
    localparam int ID_W   = 4;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    localparam logic [ID_W-1:0] NODE_CORE_LSU = 4'd1;
    localparam logic [ID_W-1:0] NODE_MASTER1  = 4'd5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              opcode;
        logic [ID_W-1:0]   src_id;
        logic [ID_W-1:0]   tgt_id;
        logic [SB_W-1:0]   sideband;
    } req_payload_t;

endpackage

// File: rtl/toy_bus_tgt_arb_if.sv
// rtl/toy_bus_tgt_arb_if.sv - one toy bus link: single-beat request channel plus ack channel
// master: issues requests (req_* out, req_rdy in) and takes acks (ack_* in, ack_rdy out)
// slave : accepts requests and returns acks
interface toy_bus_tgt_arb_if;
    import toy_bus_pkg::*;

    logic              req_vld;
    logic              req_rdy;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [STRB_W-1:0] req_strb;
    logic              req_opcode;
    logic [ID_W-1:0]   req_src_id;
    logic [ID_W-1:0]   req_tgt_id;
    logic [SB_W-1:0]   req_sideband;

    logic              ack_vld;
    logic              ack_rdy;
    logic              ack_opcode;
    logic [DATA_W-1:0] ack_data;
    logic [SB_W-1:0]   ack_sideband;
    logic [ID_W-1:0]   ack_src_id;
    logic [ID_W-1:0]   ack_tgt_id;

    modport master (
        output req_vld, req_addr, req_data, req_strb, req_opcode,
               req_src_id, req_tgt_id, req_sideband, ack_rdy,
        input  req_rdy, ack_vld, ack_opcode, ack_data, ack_sideband,
               ack_src_id, ack_tgt_id
    );

    modport slave (
        input  req_vld, req_addr, req_data, req_strb, req_opcode,
               req_src_id, req_tgt_id, req_sideband, ack_rdy,
        output req_rdy, ack_vld, ack_opcode, ack_data, ack_sideband,
               ack_src_id, ack_tgt_id
    );

endinterface

// File: rtl/toy_bus_ost_cnt.sv
// rtl/toy_bus_ost_cnt.sv - saturating outstanding-transaction counter with full flag
// ports: clk, rst_n (async, active low), inc, dec, full (cnt==MAX), underflow (dec while cnt==0)
module toy_bus_ost_cnt #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic underflow
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !dec && cnt != W'(MAX)) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign full      = (cnt == W'(MAX));
    assign underflow = dec && (cnt == '0);

endmodule

// File: rtl/toy_bus_tgt_arb.sv
// rtl/toy_bus_tgt_arb.sv - two-source round-robin target arbiter with forward slice and ack routing
// ports: clk, rst_n (async, active low); in0/in1 source links (slave); out target link (master);
//        err_unroute sticky flag for acks with unknown tgt_id or with no request outstanding
module toy_bus_tgt_arb
    import toy_bus_pkg::*;
#(
    parameter logic [ID_W-1:0] SRC_ID0 = 4'd1,
    parameter logic [ID_W-1:0] SRC_ID1 = 4'd5,
    parameter int              MAX_OST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    toy_bus_tgt_arb_if.slave  in0,
    toy_bus_tgt_arb_if.slave  in1,
    toy_bus_tgt_arb_if.master out,
    output logic              err_unroute
);

    logic         full0, full1, under0, under1;
    logic         elig0, elig1, free, gnt0, gnt1, acc0, acc1;
    logic         rr_ptr, slice_vld;
    req_payload_t slice_q, pay0, pay1;
    logic         hit0, hit1, ack_hs0, ack_hs1, unroute_hs;

    assign pay0 = '{addr: in0.req_addr, data: in0.req_data, strb: in0.req_strb,
                    opcode: in0.req_opcode, src_id: in0.req_src_id,
                    tgt_id: in0.req_tgt_id, sideband: in0.req_sideband};
    assign pay1 = '{addr: in1.req_addr, data: in1.req_data, strb: in1.req_strb,
                    opcode: in1.req_opcode, src_id: in1.req_src_id,
                    tgt_id: in1.req_tgt_id, sideband: in1.req_sideband};

    // rr_ptr only breaks ties; a lone eligible port always wins
    assign elig0 = in0.req_vld && !full0;
    assign elig1 = in1.req_vld && !full1;
    assign free  = !slice_vld || out.req_rdy;
    assign gnt0  = elig0 && (!elig1 || !rr_ptr);
    assign gnt1  = elig1 && (!elig0 ||  rr_ptr);
    assign acc0  = gnt0 && free;
    assign acc1  = gnt1 && free;

    assign in0.req_rdy = acc0;
    assign in1.req_rdy = acc1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slice_vld <= 1'b0;
            slice_q   <= '0;
            rr_ptr    <= 1'b0;
        end else if (acc0) begin
            slice_vld <= 1'b1;
            slice_q   <= pay0;
            rr_ptr    <= 1'b1;
        end else if (acc1) begin
            slice_vld <= 1'b1;
            slice_q   <= pay1;
            rr_ptr    <= 1'b0;
        end else if (out.req_rdy) begin
            slice_vld <= 1'b0;
        end
    end

    assign out.req_vld      = slice_vld;
    assign out.req_addr     = slice_q.addr;
    assign out.req_data     = slice_q.data;
    assign out.req_strb     = slice_q.strb;
    assign out.req_opcode   = slice_q.opcode;
    assign out.req_src_id   = slice_q.src_id;
    assign out.req_tgt_id   = slice_q.tgt_id;
    assign out.req_sideband = slice_q.sideband;

    // unknown tgt_id is drained (rdy=1) so a stray ack cannot wedge the target
    assign hit0       = (out.ack_tgt_id == SRC_ID0);
    assign hit1       = (out.ack_tgt_id == SRC_ID1) && !hit0;
    assign unroute_hs = out.ack_vld && !hit0 && !hit1;
    assign ack_hs0    = out.ack_vld && hit0 && in0.ack_rdy;
    assign ack_hs1    = out.ack_vld && hit1 && in1.ack_rdy;

    assign in0.ack_vld  = out.ack_vld && hit0;
    assign in1.ack_vld  = out.ack_vld && hit1;
    assign out.ack_rdy  = hit0 ? in0.ack_rdy : (hit1 ? in1.ack_rdy : 1'b1);

    assign in0.ack_opcode   = out.ack_opcode;
    assign in0.ack_data     = out.ack_data;
    assign in0.ack_sideband = out.ack_sideband;
    assign in0.ack_src_id   = out.ack_src_id;
    assign in0.ack_tgt_id   = out.ack_tgt_id;
    assign in1.ack_opcode   = out.ack_opcode;
    assign in1.ack_data     = out.ack_data;
    assign in1.ack_sideband = out.ack_sideband;
    assign in1.ack_src_id   = out.ack_src_id;
    assign in1.ack_tgt_id   = out.ack_tgt_id;

    toy_bus_ost_cnt #(.MAX(MAX_OST)) u_ost0 (
        .clk(clk), .rst_n(rst_n), .inc(acc0), .dec(ack_hs0),
        .full(full0), .underflow(under0)
    );

    toy_bus_ost_cnt #(.MAX(MAX_OST)) u_ost1 (
        .clk(clk), .rst_n(rst_n), .inc(acc1), .dec(ack_hs1),
        .full(full1), .underflow(under1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_unroute <= 1'b0;
        end else if (unroute_hs || under0 || under1) begin
            err_unroute <= 1'b1;
        end
    end

endmodule

// File: tb/tb_toy_bus_tgt_arb.sv
// tb/tb_toy_bus_tgt_arb.sv - randomized scoreboard bench for toy_bus_tgt_arb
module tb_toy_bus_tgt_arb;
    import toy_bus_pkg::*;

    localparam logic [ID_W-1:0] ID0  = 4'd1;
    localparam logic [ID_W-1:0] ID1  = 4'd5;
    localparam int              MAXO = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic err_unroute;

    always #5 clk = ~clk;

    toy_bus_tgt_arb_if u_in0 ();
    toy_bus_tgt_arb_if u_in1 ();
    toy_bus_tgt_arb_if u_out ();

    toy_bus_tgt_arb #(.SRC_ID0(ID0), .SRC_ID1(ID1), .MAX_OST(MAXO)) dut (
        .clk(clk), .rst_n(rst_n), .in0(u_in0), .in1(u_in1), .out(u_out),
        .err_unroute(err_unroute)
    );

    int total = 0;
    int bad   = 0;

    req_payload_t exp_q[$];
    req_payload_t src_pay[2];
    bit           src_vld[2];
    int           ost[2];
    int           rr;
    bit           slice_full;
    bit           err_m;
    int           vld_pct, rdy_pct, ack_pct, force_tgt;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic req_payload_t rnd_pay(input int k);
        req_payload_t p;
        p.addr = $urandom;
        for (int i = 0; i < DATA_W / 32; i++) p.data[i*32 +: 32] = $urandom;
        p.strb     = $urandom;
        p.opcode   = 1'($urandom_range(0, 1));
        p.src_id   = (k == 0) ? ID0 : ID1;
        p.tgt_id   = ID_W'($urandom_range(0, 15));
        p.sideband = SB_W'($urandom_range(0, 1023));
        return p;
    endfunction

    task automatic apply_src();
        u_in0.req_vld      = src_vld[0];
        u_in0.req_addr     = src_pay[0].addr;
        u_in0.req_data     = src_pay[0].data;
        u_in0.req_strb     = src_pay[0].strb;
        u_in0.req_opcode   = src_pay[0].opcode;
        u_in0.req_src_id   = src_pay[0].src_id;
        u_in0.req_tgt_id   = src_pay[0].tgt_id;
        u_in0.req_sideband = src_pay[0].sideband;
        u_in1.req_vld      = src_vld[1];
        u_in1.req_addr     = src_pay[1].addr;
        u_in1.req_data     = src_pay[1].data;
        u_in1.req_strb     = src_pay[1].strb;
        u_in1.req_opcode   = src_pay[1].opcode;
        u_in1.req_src_id   = src_pay[1].src_id;
        u_in1.req_tgt_id   = src_pay[1].tgt_id;
        u_in1.req_sideband = src_pay[1].sideband;
    endtask

    // one bus cycle: drive after the edge, check and advance the model at the falling edge
    task automatic step();
        bit e0, e1, free, hs0, hs1;
        int win, k;
        logic [ID_W-1:0] t;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (!src_vld[i] && $urandom_range(0, 99) < vld_pct) begin
                src_vld[i] = 1'b1;
                src_pay[i] = rnd_pay(i);
            end
        end
        apply_src();
        u_out.req_rdy = ($urandom_range(0, 99) < rdy_pct);
        u_out.ack_vld = 1'b0;
        if (force_tgt >= 0) begin
            u_out.ack_vld    = 1'b1;
            u_out.ack_tgt_id = ID_W'(force_tgt);
            force_tgt        = -1;
        end else if ($urandom_range(0, 99) < ack_pct) begin
            k = $urandom_range(0, 1);
            if (ost[k] > 0) begin
                u_out.ack_vld    = 1'b1;
                u_out.ack_tgt_id = (k == 0) ? ID0 : ID1;
            end
        end
        u_out.ack_opcode   = 1'($urandom_range(0, 1));
        u_out.ack_data     = {8{$urandom}};
        u_out.ack_sideband = SB_W'($urandom_range(0, 1023));
        u_out.ack_src_id   = ID_W'($urandom_range(0, 15));
        u_in0.ack_rdy      = ($urandom_range(0, 99) < 75);
        u_in1.ack_rdy      = ($urandom_range(0, 99) < 75);

        @(negedge clk);
        chk("out_req_vld", u_out.req_vld, slice_full);
        chk("err_unroute", err_unroute, err_m);
        e0   = src_vld[0] && ost[0] < MAXO;
        e1   = src_vld[1] && ost[1] < MAXO;
        free = !slice_full || u_out.req_rdy;
        win  = -1;
        if (e0 && e1) win = rr;
        else if (e0)  win = 0;
        else if (e1)  win = 1;
        chk("in0_req_rdy", u_in0.req_rdy, free && win == 0);
        chk("in1_req_rdy", u_in1.req_rdy, free && win == 1);

        t   = u_out.ack_tgt_id;
        hs0 = u_out.ack_vld && t == ID0 && u_in0.ack_rdy;
        hs1 = u_out.ack_vld && t == ID1 && u_in1.ack_rdy;
        chk("in0_ack_vld", u_in0.ack_vld, u_out.ack_vld && t == ID0);
        chk("in1_ack_vld", u_in1.ack_vld, u_out.ack_vld && t == ID1);
        chk("out_ack_rdy", u_out.ack_rdy,
            (t == ID0) ? u_in0.ack_rdy : ((t == ID1) ? u_in1.ack_rdy : 1'b1));
        chk("ack_fanout", {u_in0.ack_data, u_in1.ack_sideband, u_in1.ack_opcode},
            {u_out.ack_data, u_out.ack_sideband, u_out.ack_opcode});

        if (u_out.ack_vld && t != ID0 && t != ID1) err_m = 1'b1;
        if (hs0) begin if (ost[0] == 0) err_m = 1'b1; else ost[0]--; end
        if (hs1) begin if (ost[1] == 0) err_m = 1'b1; else ost[1]--; end
        if (win >= 0 && free) begin
            exp_q.push_back(src_pay[win]);
            ost[win]++;
            rr           = 1 - win;
            src_vld[win] = 1'b0;
            slice_full   = 1'b1;
        end else if (u_out.req_rdy) begin
            slice_full = 1'b0;
        end
    endtask

    task automatic run(input int n, input int v, input int r, input int a);
        vld_pct = v; rdy_pct = r; ack_pct = a;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic model_reset();
        exp_q.delete();
        ost[0] = 0; ost[1] = 0;
        rr = 0; slice_full = 1'b0; err_m = 1'b0;
    endtask

    // monitor: the slice head must match the oldest accepted request, every cycle it is valid
    always @(negedge clk) begin
        req_payload_t got;
        if (rst_n && u_out.req_vld) begin
            got = '{addr: u_out.req_addr, data: u_out.req_data, strb: u_out.req_strb,
                    opcode: u_out.req_opcode, src_id: u_out.req_src_id,
                    tgt_id: u_out.req_tgt_id, sideband: u_out.req_sideband};
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_req_extra: got vld=1 expected no request");
            end else begin
                chk("out_req_payload", got, exp_q[0]);
                if (u_out.req_rdy) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        force_tgt = -1;
        src_vld[0] = 1'b0; src_vld[1] = 1'b0;
        src_pay[0] = '0;   src_pay[1] = '0;
        apply_src();
        u_out.req_rdy = 1'b0; u_out.ack_vld = 1'b0; u_out.ack_tgt_id = '0;
        u_out.ack_opcode = 1'b0; u_out.ack_data = '0; u_out.ack_sideband = '0;
        u_out.ack_src_id = '0; u_in0.ack_rdy = 1'b0; u_in1.ack_rdy = 1'b0;
        model_reset();
        #12;
        chk("rst_out_req_vld", u_out.req_vld, 1'b0);
        chk("rst_out_req_addr", u_out.req_addr, '0);
        chk("rst_err_unroute", err_unroute, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;

        src_vld[0] = 1'b1;
        src_pay[0] = rnd_pay(0);
        src_pay[0].addr = 32'h8000_0000;
        run(3, 0, 100, 0);
        run(4, 100, 100, 0);
        run(3, 100, 0, 0);
        run(6, 100, 100, 0);
        run(12, 100, 100, 60);
        run(400, 60, 70, 30);

        force_tgt = 9;
        run(3, 30, 100, 0);

        run(8, 100, 100, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_out_req_vld", u_out.req_vld, 1'b0);
        chk("async_rst_err_unroute", err_unroute, 1'b0);
        model_reset();
        u_in0.req_vld = 1'b0; u_in1.req_vld = 1'b0; u_out.ack_vld = 1'b0;
        src_vld[0] = 1'b1; src_vld[1] = 1'b1;
        src_pay[0] = rnd_pay(0); src_pay[1] = rnd_pay(1);
        @(posedge clk); #1 rst_n = 1'b1;
        run(6, 100, 100, 20);

        run(5, 0, 100, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/toy_bus_tgt_arb.md
Name: toy_bus_tgt_arb

Overview:
Target-side arbiter for the toy bus. Two source nodes (for example the LSU core-slave node and a second master node) share one target request channel. Requests are single-beat; the block round-robins between them, registers the winner in a one-entry forward slice and caps each source's in-flight transactions. Acks from the target are routed back to the source named in ack tgt_id.

Parameters:
ADDR_W, 32, request address width
DATA_W, 256, data width
STRB_W, 32, byte-strobe width
SB_W, 10, sideband width
ID_W, 4, src/tgt id width
SRC_ID0, 4'd1, bus id of the source on port in0
SRC_ID1, 4'd5, bus id of the source on port in1
MAX_OST, 4, maximum outstanding requests per source (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
inK_req_vld  in  1  request valid (K = 0,1; this applies to every inK_ line)
inK_req_rdy  out  1  request accepted when vld&&rdy
inK_req_addr/data/strb  in  ADDR_W/DATA_W/STRB_W  request payload
inK_req_opcode  in  1  0 = read, 1 = write
inK_req_src_id/tgt_id  in  ID_W  ids set by the source node
inK_req_sideband  in  SB_W  opaque sideband
inK_ack_vld  out  1  ack valid toward source K
inK_ack_rdy  in  1  source K accepts ack
inK_ack_opcode/data/sideband  out  1/DATA_W/SB_W  ack payload
out_req_vld  out  1  registered request to target
out_req_rdy  in  1  target accepts
out_req_addr/data/strb/opcode/src_id/tgt_id/sideband  out  as input  registered payload
out_ack_vld  in  1  ack from target
out_ack_rdy  out  1  ack accepted
out_ack_opcode/data/sideband/src_id/tgt_id  in  1/DATA_W/SB_W/ID_W/ID_W  ack payload
err_unroute  out  1  sticky: an ack arrived with an unknown tgt_id

Behaviour:
- Reset (rst_n low, asynchronous): out_req_vld=0, all out_req_* payload=0, rr_ptr=0 (in0 has priority), ost0=ost1=0, err_unroute=0. Any request held in the slice is discarded.
- Eligibility: eligK = inK_req_vld && (ostK < MAX_OST).
- Slice free: free = !out_req_vld || out_req_rdy.
- Grant (combinational):
  - Only one port eligible: that port wins.
  - Both eligible: port rr_ptr wins.
  - Winner's inK_req_rdy = free. The loser's rdy=0. A non-eligible port's rdy=0.
- On accept (vld&&rdy of port K):
  - Next edge: slice loads port K's payload and out_req_vld=1. Latency is exactly 1 cycle.
  - rr_ptr becomes the other port (~K).
  - rr_ptr is unchanged in cycles with no grant.
- Slice behaviour:
  - out_req_vld && out_req_rdy with no new accept: out_req_vld clears next cycle.
  - Handshake and accept in the same cycle: back-to-back throughput, 1 request/cycle.
  - While out_req_vld && !out_req_rdy the payload holds stable.
- Ack routing (combinational, 0 latency):
  - out_ack_tgt_id == SRC_ID0: in0_ack_vld = out_ack_vld, out_ack_rdy = in0_ack_rdy.
  - out_ack_tgt_id == SRC_ID1: the same through in1.
  - Otherwise: both inK_ack_vld=0, out_ack_rdy=1 (the ack is drained) and err_unroute sets on the handshake. It clears only on reset.
  - Ack payload fans out to both ports unconditionally.
- Outstanding counters, width clog2(MAX_OST+1):
  - ostK +1 on a port K request accept.
  - ostK -1 on a port K ack handshake.
  - Both in the same cycle: unchanged.
  - At MAX_OST the port is ineligible; the boundary is exact, so the count never exceeds MAX_OST.
  - An ack arriving with ostK==0 (protocol error): the counter saturates at 0 and err_unroute sets.
- No locking: every request is single-beat. A source may change its payload only after its handshake.

Decomposition:
- Shared package toy_bus_pkg:
  - ID_W, ADDR_W, DATA_W, STRB_W, SB_W.
  - Opcode constants OP_RD=0, OP_WR=1.
  - Node-id constants (core LSU=1 etc.).
- One sub-module, toy_bus_ost_cnt: saturating up/down counter with a full flag, instantiated per source.
- Arbitration and slice stay in the top module.

Test Plan:
- Single source: in0 sends addr 0x8000_0000 with out_req_rdy=1 -> out_req_vld high one cycle later, out_req_addr=0x8000_0000, src_id=1.
- Contention: in0 and in1 both valid for 4 cycles with out_req_rdy=1 -> grants in0,in1,in0,in1; out_req_src_id sequence 1,5,1,5.
- Backpressure: out_req_rdy=0 for 3 cycles while the slice is full -> both inK_req_rdy=0 and the payload is stable. rdy=1 -> the next request follows with no bubble.
- Outstanding cap: in0 issues 4 requests with no acks -> 5th stalls (in0_req_rdy=0) while in1 is still granted. One ack with tgt_id=1 -> the 5th is accepted the cycle after.
- Ack routing and simultaneous events:
  - Ack tgt_id=5 -> only in1_ack_vld is high.
  - Ack for in0 coincides with an in0 accept -> ost0 unchanged.
  - Ack tgt_id=9 -> drained, err_unroute=1.
- Reset mid-operation: assert rst_n=0 with the slice full and ost0=3 -> out_req_vld=0 and counters 0 immediately, without waiting for clk. The first request after release is granted to in0.
